pc_sequencer: RTL and testbench

Parametrised program-counter sequencer that replaces the fixed 5-bit PC block in the fetch stage. It computes the next instruction address each cycle from a source select: sequential, relative jump, skip, call and return. Call and return use an internal return-address stack (RAS). A stall input freezes fetch, and the registered PC drives instruction memory directly.

---
 rtl/pc_sequencer_pkg.sv | 14 +
 rtl/pc_sequencer_ras.sv | 71 +++++++
 rtl/pc_sequencer.sv | 91 +++++++++
 tb/tb_pc_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the PC sequencer: next-PC source encodings and reset levels.
package pc_sequencer_pkg;

    localparam logic [2:0] PC_SRC_DFT  = 3'd0;
    localparam logic [2:0] PC_SRC_JMP  = 3'd1;
    localparam logic [2:0] PC_SRC_SKIP = 3'd2;
    localparam logic [2:0] PC_SRC_CALL = 3'd3;
    localparam logic [2:0] PC_SRC_RET  = 3'd4;

    // Reset is active-low.
    localparam logic RESET   = 1'b0;
    localparam logic UNRESET = 1'b1;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: push writes top+1, pop reads top; a push on a
// full stack overwrites the oldest entry. Only built when PC_RAS_EN is defined.
module pc_ras
    import pc_sequencer_pkg::*;
#(
    parameter int PC_WIDTH  = 5,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         Reset,
    input  logic                         stall_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [PC_WIDTH-1:0]          data_i,
    output logic [PC_WIDTH-1:0]          top_o,
    output logic [$clog2(RAS_DEPTH):0]   count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]    top_q;
    logic [CNT_W-1:0]    count_q;
    logic                ovf_q;
    logic                unf_q;
    logic                full;
    logic                empty;

    assign full  = (count_q == CNT_W'(RAS_DEPTH));
    assign empty = (count_q == '0);

    always_ff @(posedge clock or negedge Reset) begin
        if (Reset == RESET) begin
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            if (!stall_i) begin
                if (push_i) begin
                    top_q <= top_q + PTR_W'(1);
                    if (full) ovf_q   <= 1'b1;
                    else      count_q <= count_q + CNT_W'(1);
                end else if (pop_i) begin
                    if (empty) begin
                        unf_q <= 1'b1;
                    end else begin
                        top_q   <= top_q - PTR_W'(1);
                        count_q <= count_q - CNT_W'(1);
                    end
                end
            end
        end
    end

    // Entry contents need no reset; only pointer and count define validity.
    always_ff @(posedge clock) begin
        if (!stall_i && push_i) mem_q[top_q + PTR_W'(1)] <= data_i;
    end

    assign top_o       = mem_q[top_q];
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, source decode and adder.
// Define PC_RAS_EN to build the return-address stack; otherwise CALL=JMP, RET=DFT.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_WIDTH     = 5,
    parameter int IMM_WIDTH    = 5,
    parameter int RAS_DEPTH    = 4,
    parameter int RESET_VECTOR = 0
) (
    input  logic                         clock,
    input  logic                         Reset,
    input  logic                         stall,
    input  logic [2:0]                   sig_pc_src,
    input  logic [IMM_WIDTH-1:0]         J_TypeImmediate,
    output logic [PC_WIDTH-1:0]          PC,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic [PC_WIDTH-1:0] imm_ext;

    if (IMM_WIDTH >= PC_WIDTH) begin : g_imm_trunc
        assign imm_ext = J_TypeImmediate[PC_WIDTH-1:0];
    end else begin : g_imm_sext
        assign imm_ext = {{(PC_WIDTH-IMM_WIDTH){J_TypeImmediate[IMM_WIDTH-1]}}, J_TypeImmediate};
    end

    assign pc_plus1 = pc_q + PC_WIDTH'(1);

`ifdef PC_RAS_EN
    logic [PC_WIDTH-1:0]        ras_top;
    logic [$clog2(RAS_DEPTH):0] ras_cnt;
    logic                       is_call;
    logic                       is_ret;

    assign is_call = (sig_pc_src == PC_SRC_CALL);
    assign is_ret  = (sig_pc_src == PC_SRC_RET);

    pc_ras #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock       (clock),
        .Reset       (Reset),
        .stall_i     (stall),
        .push_i      (is_call),
        .pop_i       (is_ret),
        .data_i      (pc_plus1),
        .top_o       (ras_top),
        .count_o     (ras_cnt),
        .overflow_o  (ras_overflow),
        .underflow_o (ras_underflow)
    );

    assign ras_count = ras_cnt;
`else
    assign ras_count     = '0;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    always_comb begin
        pc_d = pc_plus1;
        case (sig_pc_src)
            PC_SRC_DFT:  pc_d = pc_plus1;
            PC_SRC_JMP:  pc_d = pc_q + imm_ext;
            PC_SRC_SKIP: pc_d = pc_q + PC_WIDTH'(2);
            PC_SRC_CALL: pc_d = pc_q + imm_ext;
`ifdef PC_RAS_EN
            // Popping an empty stack falls through to sequential fetch.
            PC_SRC_RET:  pc_d = (ras_cnt == '0) ? pc_plus1 : ras_top;
`else
            PC_SRC_RET:  pc_d = pc_plus1;
`endif
            default:     pc_d = pc_plus1;
        endcase
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (Reset == RESET) pc_q <= PC_WIDTH'(RESET_VECTOR);
        else if (!stall)    pc_q <= pc_d;
    end

    assign PC = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a queue-based reference model; covers both
// the PC_RAS_EN and the plain build.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int DEPTH = 4;
    localparam int MASK  = 31;

    logic       clock = 1'b0;
    logic       Reset = UNRESET;
    logic       stall = 1'b0;
    logic [2:0] sig_pc_src = PC_SRC_DFT;
    logic [4:0] J_TypeImmediate = 5'd0;
    logic [4:0] PC;
    logic [2:0] ras_count;
    logic       ras_overflow;
    logic       ras_underflow;

    int n_vec  = 0;
    int n_fail = 0;

    pc_sequencer dut (
        .clock           (clock),
        .Reset           (Reset),
        .stall           (stall),
        .sig_pc_src      (sig_pc_src),
        .J_TypeImmediate (J_TypeImmediate),
        .PC              (PC),
        .ras_count       (ras_count),
        .ras_overflow    (ras_overflow),
        .ras_underflow   (ras_underflow)
    );

    always #5 clock = ~clock;

    // Reference model: PC as an integer, stack as a queue (back = most recent).
    int m_pc  = 0;
    int m_ras [$];
    int m_ovf = 0;
    int m_unf = 0;

    always @(posedge clock or negedge Reset) begin
        int nxt;
        int imm;
        if (Reset == RESET) begin
            m_pc = 0;
            m_ras.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            m_ovf = 0;
            m_unf = 0;
            if (!stall) begin
                imm = int'($signed(J_TypeImmediate));
                nxt = m_pc + 1;
                case (sig_pc_src)
                    3'd1: nxt = m_pc + imm;
                    3'd2: nxt = m_pc + 2;
                    3'd3: begin
`ifdef PC_RAS_EN
                        if (m_ras.size() == DEPTH) begin
                            m_ovf = 1;
                            void'(m_ras.pop_front());
                        end
                        m_ras.push_back((m_pc + 1) & MASK);
`endif
                        nxt = m_pc + imm;
                    end
                    3'd4: begin
`ifdef PC_RAS_EN
                        if (m_ras.size() == 0) m_unf = 1;
                        else nxt = m_ras.pop_back();
`endif
                    end
                    default: nxt = m_pc + 1;
                endcase
                m_pc = nxt & MASK;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("model_pc",  int'(PC), m_pc);
        chk("model_cnt", int'(ras_count), m_ras.size());
        chk("model_ovf", int'(ras_overflow), m_ovf);
        chk("model_unf", int'(ras_underflow), m_unf);
    end

    function automatic int pick(input int with_ras, input int without_ras);
`ifdef PC_RAS_EN
        return with_ras;
`else
        return without_ras;
`endif
    endfunction

    task automatic step(input logic [2:0] src, input logic [4:0] imm, input logic st);
        sig_pc_src      = src;
        J_TypeImmediate = imm;
        stall           = st;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // 1: reset, sequential, skip, reserved select
        #1 Reset = RESET;
        @(posedge clock); @(posedge clock); #1;
        chk("rst_pc", int'(PC), 0);
        chk("rst_cnt", int'(ras_count), 0);
        Reset = UNRESET;
        chk("rel_pc", int'(PC), 0);
        for (int i = 1; i <= 3; i++) begin
            step(PC_SRC_DFT, 5'd0, 1'b0);
            chk("dft_pc", int'(PC), i);
        end
        step(PC_SRC_SKIP, 5'd0, 1'b0);  chk("skip_pc", int'(PC), 5);
        step(3'd6, 5'd9, 1'b0);         chk("rsvd_pc", int'(PC), 6);

        // 2: signed jumps with wrap
        step(PC_SRC_JMP, 5'b11101, 1'b0); chk("jmp_m3", int'(PC), 3);
        step(PC_SRC_JMP, 5'b11011, 1'b0); chk("jmp_m5", int'(PC), 30);
        step(PC_SRC_DFT, 5'd0, 1'b0);     chk("wrap31", int'(PC), 31);
        step(PC_SRC_DFT, 5'd0, 1'b0);     chk("wrap0", int'(PC), 0);

        // 3: call / return
        for (int i = 0; i < 4; i++) step(PC_SRC_DFT, 5'd0, 1'b0);
        chk("pre_call", int'(PC), 4);
        step(PC_SRC_CALL, 5'd10, 1'b0);
        chk("call_pc", int'(PC), 14);
        chk("call_cnt", int'(ras_count), pick(1, 0));
        step(PC_SRC_RET, 5'd0, 1'b0);
        chk("ret_pc", int'(PC), pick(5, 15));
        chk("ret_cnt", int'(ras_count), 0);

        // 4: overflow and underflow
        #2 Reset = RESET;
        #1 chk("rst2_pc", int'(PC), 0);
        #2 Reset = UNRESET;
        for (int i = 1; i <= 5; i++) begin
            step(PC_SRC_CALL, 5'd1, 1'b0);
            chk("ovf_pc", int'(PC), i);
            chk("ovf_cnt", int'(ras_count), pick((i > 4) ? 4 : i, 0));
            chk("ovf_flag", int'(ras_overflow), pick((i == 5) ? 1 : 0, 0));
        end
        for (int i = 0; i < 4; i++) begin
            step(PC_SRC_RET, 5'd0, 1'b0);
            chk("pop_pc", int'(PC), pick(5 - i, 6 + i));
            chk("pop_ovf", int'(ras_overflow), 0);
        end
        step(PC_SRC_RET, 5'd0, 1'b0);
        chk("unf_pc", int'(PC), pick(3, 10));
        chk("unf_flag", int'(ras_underflow), pick(1, 0));
        step(PC_SRC_DFT, 5'd0, 1'b0);
        chk("unf_clr", int'(ras_underflow), 0);
        chk("unf_next", int'(PC), pick(4, 11));

        // 5: stall then asynchronous reset mid-sequence
        step(PC_SRC_CALL, 5'd2, 1'b0);
        step(PC_SRC_CALL, 5'd3, 1'b0);
        chk("pre_stall_pc", int'(PC), pick(9, 16));
        chk("pre_stall_cnt", int'(ras_count), pick(2, 0));
        for (int i = 0; i < 3; i++) begin
            step(PC_SRC_CALL, 5'd7, 1'b1);
            chk("stall_pc", int'(PC), pick(9, 16));
            chk("stall_cnt", int'(ras_count), pick(2, 0));
            chk("stall_ovf", int'(ras_overflow), 0);
        end
        step(PC_SRC_RET, 5'd0, 1'b0);
        chk("post_stall_pc", int'(PC), pick(7, 17));
        #2 Reset = RESET;
        #1;
        chk("async_pc", int'(PC), 0);
        chk("async_cnt", int'(ras_count), 0);
        #2 Reset = UNRESET;

        // 6: call / return at PC=2
        step(PC_SRC_DFT, 5'd0, 1'b0);
        step(PC_SRC_DFT, 5'd0, 1'b0);
        step(PC_SRC_CALL, 5'd3, 1'b0);
        chk("c6_pc", int'(PC), 5);
        chk("c6_cnt", int'(ras_count), pick(1, 0));
        step(PC_SRC_RET, 5'd0, 1'b0);
        chk("r6_pc", int'(PC), pick(3, 6));
        chk("r6_flags", int'(ras_overflow) + int'(ras_underflow), 0);

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
